// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared constants and helpers for the programmable sequence detector
package seqdet_pkg;

  localparam logic [7:0]  SEQDET_DEF_PATTERN = 8'b0001_0110;
  localparam int unsigned SEQDET_DEF_LEN     = 5;
  localparam bit          SEQDET_DEF_OVERLAP = 1'b1;

  function automatic int unsigned seqdet_len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low len bits set; callers truncate to their own pattern width.
  function automatic logic [31:0] seqdet_len_mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seqdet_masked_cmp.sv
// rtl/seqdet_masked_cmp.sv - compares the low len history bits against the pattern
module seqdet_masked_cmp
  import seqdet_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W   = seqdet_len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] i_hist_n,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit
);

  logic [MAX_LEN-1:0] w_mask;

  assign w_mask = MAX_LEN'(seqdet_len_mask(32'(i_len)));
  assign o_hit  = (i_len != '0) && (((i_hist_n ^ i_pattern) & w_mask) == '0);

endmodule

// File: rtl/seq_detector_moore_prog.sv
// rtl/seq_detector_moore_prog.sv - Moore serial pattern detector with runtime pattern/length/overlap
module seq_detector_moore_prog
  import seqdet_pkg::*;
#(
  parameter  int unsigned        MAX_LEN     = 8,
  parameter  int unsigned        CNT_W       = 8,
  parameter  logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQDET_DEF_PATTERN),
  parameter  int unsigned        DEF_LEN     = SEQDET_DEF_LEN,
  parameter  bit                 DEF_OVERLAP = SEQDET_DEF_OVERLAP,
  localparam int unsigned        LEN_W       = seqdet_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               j,
  input  logic               clr_count,
  output logic               w,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  logic [MAX_LEN-1:0] r_hist,    w_hist_nxt;
  logic [LEN_W-1:0]   r_fill,    w_fill_nxt;
  logic               r_w,       w_w_nxt;
  logic [CNT_W-1:0]   r_count,   w_count_nxt;
  logic [MAX_LEN-1:0] r_pattern, w_pattern_nxt;
  logic [LEN_W-1:0]   r_len,     w_len_nxt;
  logic               r_overlap, w_overlap_nxt;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_cmp_hit;
  logic               w_hit;

  assign w_accept      = in_valid && !cfg_we;
  assign w_hist_shift  = {r_hist[MAX_LEN-2:0], j};
  assign w_fill_inc    = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
  assign w_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  seqdet_masked_cmp #(
    .MAX_LEN (MAX_LEN)
  ) u_cmp (
    .i_hist_n  (w_hist_shift),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_hit     (w_cmp_hit)
  );

  // A match only counts once len fresh bits are in the history window.
  assign w_hit = w_accept && (w_fill_inc == r_len) && w_cmp_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_w       <= 1'b0;
      r_count   <= '0;
      r_pattern <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
    end else begin
      r_hist    <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      r_w       <= w_w_nxt;
      r_count   <= w_count_nxt;
      r_pattern <= w_pattern_nxt;
      r_len     <= w_len_nxt;
      r_overlap <= w_overlap_nxt;
    end
  end

  always_comb begin
    w_hist_nxt    = r_hist;
    w_fill_nxt    = r_fill;
    w_w_nxt       = 1'b0;
    w_pattern_nxt = r_pattern;
    w_len_nxt     = r_len;
    w_overlap_nxt = r_overlap;
    w_count_nxt   = r_count;

    if (cfg_we) begin
      w_pattern_nxt = cfg_pattern;
      w_len_nxt     = w_len_clamped;
      w_overlap_nxt = cfg_overlap;
      w_hist_nxt    = '0;
      w_fill_nxt    = '0;
    end else if (w_accept) begin
      w_hist_nxt = w_hist_shift;
      w_fill_nxt = (w_hit && !r_overlap) ? '0 : w_fill_inc;
      w_w_nxt    = w_hit;
    end

    if (clr_count) begin
      w_count_nxt = '0;
    end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w           = r_w;
    fill        = r_fill;
    match_count = r_count;
  end

endmodule

// File: tb/tb_seq_detector_moore_prog.sv
// tb/tb_seq_detector_moore_prog.sv - directed self-checking bench for seq_detector_moore_prog
module tb_seq_detector_moore_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_overlap, in_valid, j, clr_count;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       w;
  logic [7:0] match_count;
  logic [3:0] fill;

  logic       c_cfg_we, c_overlap, c_valid, c_j, c_clr;
  logic [7:0] c_pattern;
  logic [3:0] c_len;
  logic       c_w;
  logic [1:0] c_count;
  logic [3:0] c_fill;

  int checks   = 0;
  int failures = 0;
  int ref_st   = 0;

  always #5 clk = ~clk;

  seq_detector_moore_prog dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .j(j), .clr_count(clr_count),
    .w(w), .match_count(match_count), .fill(fill)
  );

  seq_detector_moore_prog #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .cfg_we(c_cfg_we), .cfg_pattern(c_pattern), .cfg_len(c_len),
    .cfg_overlap(c_overlap), .in_valid(c_valid), .j(c_j), .clr_count(c_clr),
    .w(c_w), .match_count(c_count), .fill(c_fill)
  );

  // Legacy 10110 overlapping FSM: states A..F = 0..5, output high in F.
  function automatic int legacy_next(input int st, input logic b);
    case (st)
      0: return b ? 1 : 0;
      1: return b ? 1 : 2;
      2: return b ? 3 : 0;
      3: return b ? 4 : 2;
      4: return b ? 1 : 5;
      default: return b ? 3 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic jv, input logic vld, input logic exp_w, input string tag);
    j        = jv;
    in_valid = vld;
    tick();
    chk(tag, 32'(w), 32'(exp_w));
  endtask

  task automatic cfg_load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    in_valid    = 1'b0;
    tick();
    cfg_we = 1'b0;
    chk("cfg_fill", 32'(fill), 0);
    chk("cfg_w", 32'(w), 0);
  endtask

  task automatic legacy_step(input logic b, input logic exp_w);
    ref_st = legacy_next(ref_st, b);
    step(b, 1'b1, exp_w, "legacy_w");
    chk("legacy_ref", 32'(w), 32'(ref_st == 5));
  endtask

  logic [12:0] legacy_bits = 13'b1011011010110;
  logic [12:0] legacy_exp  = 13'b0000100100001;
  logic [8:0]  post_bits   = 9'b011010110;
  logic [7:0]  p8_bits     = 8'b1100_1010;

  initial begin
    rst = 1'b1;
    cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; j = 0; clr_count = 0;
    c_cfg_we = 0; c_pattern = '0; c_len = '0; c_overlap = 0; c_valid = 0; c_j = 0; c_clr = 0;
    #12;
    chk("rst_w", 32'(w), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_count", 32'(match_count), 0);
    rst = 1'b0;

    for (int i = 12; i >= 0; i--) legacy_step(legacy_bits[i], legacy_exp[i]);
    chk("legacy_count", 32'(match_count), 3);

    step(1, 1, 0, "pre_rst_1");
    step(0, 1, 0, "pre_rst_0");
    step(1, 1, 0, "pre_rst_1");
    step(1, 1, 0, "pre_rst_1");
    #3 rst = 1'b1;
    #1;
    chk("async_w", 32'(w), 0);
    chk("async_fill", 32'(fill), 0);
    chk("async_count", 32'(match_count), 0);
    #2 rst = 1'b0;
    ref_st = 0;
    for (int i = 8; i >= 0; i--) begin
      legacy_step(post_bits[i], (i == 0));
      if (i == 5) chk("post_rst_fill", 32'(fill), 4);
    end
    chk("post_rst_count", 32'(match_count), 1);

    cfg_load(8'b101, 4'd3, 1'b0);
    step(1, 1, 0, "novl_b1"); step(0, 1, 0, "novl_b2"); step(1, 1, 1, "novl_b3");
    step(0, 1, 0, "novl_b4"); step(1, 1, 0, "novl_b5");
    chk("novl_count", 32'(match_count), 2);

    cfg_load(8'b101, 4'd3, 1'b1);
    step(1, 1, 0, "ovl_b1"); step(0, 1, 0, "ovl_b2"); step(1, 1, 1, "ovl_b3");
    step(0, 1, 0, "ovl_b4"); step(1, 1, 1, "ovl_b5");
    chk("ovl_count", 32'(match_count), 4);

    cfg_load(8'b110, 4'd3, 1'b1);
    step(1, 1, 0, "qual_b1"); step(1, 0, 0, "qual_gap"); step(1, 0, 0, "qual_gap");
    step(1, 1, 0, "qual_b2"); step(1, 0, 0, "qual_gap"); step(1, 0, 0, "qual_gap");
    step(0, 1, 1, "qual_b3"); step(1, 0, 0, "qual_gap"); step(1, 0, 0, "qual_gap");
    chk("qual_count", 32'(match_count), 5);

    cfg_load(8'b1000_0001, 4'd8, 1'b1);
    step(1, 1, 0, "len8_b1");
    for (int i = 0; i < 6; i++) step(0, 1, 0, "len8_b0");
    chk("len8_fill7", 32'(fill), 7);
    step(1, 1, 1, "len8_b8");

    cfg_load(8'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, "len0_w");
    chk("len0_fill", 32'(fill), 0);

    cfg_load(8'b1100_1010, 4'd12, 1'b1);
    for (int i = 7; i >= 0; i--) step(p8_bits[i], 1, (i == 0), "len12_w");
    chk("len12_fill", 32'(fill), 8);
    chk("len12_count", 32'(match_count), 7);

    cfg_we = 1; cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1; in_valid = 1; j = 1;
    tick();
    cfg_we = 0;
    chk("cfg_drop_fill", 32'(fill), 0);
    chk("cfg_drop_w", 32'(w), 0);
    step(1, 1, 0, "cfg_drop_b1"); step(1, 1, 1, "consec_b2"); step(1, 1, 1, "consec_b3");
    chk("consec_count", 32'(match_count), 9);
    in_valid = 0;

    c_cfg_we = 1; c_pattern = 8'b1; c_len = 4'd1; c_overlap = 1;
    tick();
    c_cfg_we = 0; c_valid = 1; c_j = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_w", 32'(c_w), 1);
      chk("sat_count", 32'(c_count), (i < 3) ? i : 3);
    end
    c_clr = 1;
    tick();
    chk("clr_hit_count", 32'(c_count), 0);
    chk("clr_hit_w", 32'(c_w), 1);
    c_clr = 0;
    tick();
    chk("after_clr_count", 32'(c_count), 1);
    c_valid = 0;
    tick();
    chk("idle_w", 32'(c_w), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_moore_prog.md
Name: seq_detector_moore_prog

Overview:
- Parametrised successor of the fixed 5-bit Moore sequence detector.
- Serial bit-stream detector with a runtime-programmable pattern (1..MAX_LEN bits).
- Selectable overlapping or non-overlapping match mode, input qualifier, and a saturating match counter.
- Output w is Moore (registered); defaults reproduce the legacy overlapping 10110 detector exactly. Sits between the serial input synchroniser and the match-event consumer.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- DEF_PATTERN, 8'b0001_0110, pattern loaded at reset; right-aligned, width MAX_LEN.
- DEF_LEN, 5, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  load configuration this cycle.
- cfg_pattern  in  MAX_LEN  pattern; the first expected bit is cfg_pattern[cfg_len-1], the last is bit 0.
- cfg_len  in  LEN_W  pattern length; LEN_W = $clog2(MAX_LEN+1).
- cfg_overlap  in  1  1 = overlapping matches allowed.
- in_valid  in  1  j is sampled only when high.
- j  in  1  serial data bit.
- clr_count  in  1  synchronous clear of match_count.
- w  out  1  Moore match output.
- match_count  out  CNT_W  saturating count of matches.
- fill  out  LEN_W  number of valid history bits, saturating at the active length.

Behaviour:
- Reset (async) values:
  - hist=0, fill=0, w=0, match_count=0.
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
- State held per cycle:
  - hist: MAX_LEN-bit shift register.
  - fill.
  - Configuration registers.
  - w register.
- Accepted bit (in_valid=1, cfg_we=0):
  - hist_n = {hist[MAX_LEN-2:0], j}.
  - fill_n = min(fill+1, len).
- Match condition: hit = (fill_n == len) && len != 0 && ((hist_n ^ pattern) & mask) == 0, where mask has the low len bits set.
- w timing:
  - w <= hit at the same edge, so w is high for the full cycle after the edge that sampled the completing bit.
  - Latency 1 clock; no combinational path from j to w.
- After a hit:
  - overlap=1: hist and fill advance normally.
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
- No accepted bit (in_valid=0):
  - hist and fill hold; w <= 0.
  - A match therefore pulses w exactly one cycle.
- Consecutive completing bits (e.g. pattern 11, overlap=1, input 111):
  - w stays high on consecutive cycles, one cycle per match.
- Configuration load (cfg_we=1):
  - pattern, len and overlap load; hist=0, fill=0, w<=0.
  - A j bit arriving in the same cycle is dropped (config wins).
  - match_count is unaffected.
- cfg_len handling:
  - cfg_len == 0: detector disabled; w never asserts, hist still shifts.
  - cfg_len > MAX_LEN: clamped to MAX_LEN at load.
- match_count:
  - Increments on each hit.
  - Saturates at 2^CNT_W-1 (no wrap).
  - clr_count forces 0 and takes priority over a simultaneous hit (that hit is not counted).
- Reset mid-stream: everything returns to reset values immediately, independent of clk; partial prefixes are lost.
- Legacy equivalence:
  - With default parameters and no cfg_we, w must equal the legacy A–F 10110 FSM output on every cycle for any j stream with in_valid=1.
  - Verification compares both cycle-by-cycle.

Decomposition:
- Package seqdet_pkg:
  - LEN_W computation function.
  - Default pattern/length/overlap constants.
  - mask-from-length function.
- One sub-module, seqdet_masked_cmp (combinational): takes hist_n, pattern, len; outputs hit.
- Top level holds the registers, config logic and counter.

Test Plan:
- Legacy compare, defaults, in_valid=1, stream 1011011010110 vs legacy FSM -> w pulses after bit 5, bit 8 and bit 13 (three pulses); match_count=3; zero mismatches vs reference model.
- Non-overlap: load pattern 101 (len=3, overlap=0), stream 10101 -> one pulse, after bit 3 only; with overlap=1 the same stream -> pulses after bits 3 and 5.
- Qualifier: pattern 110, bits 1,1,0 interleaved with in_valid=0 gaps of 2 cycles -> single 1-cycle w pulse one clock after the valid 0 is sampled; w=0 during the gaps.
- Boundaries:
  - len=MAX_LEN=8, pattern 10000001 -> match after exactly 8 bits.
  - cfg_len=0 -> no w ever.
  - cfg_len=12 -> reads back as 8-bit behaviour.
  - cfg_we concurrent with a valid bit -> bit dropped, fill=0.
- Counter: CNT_W=2, pattern 1 (len=1), 5 consecutive 1s -> match_count sticks at 3; clr_count together with a hit -> count 0.
- Async reset: assert rst mid-pattern (after 1011) off a clock edge -> w=0, fill=0 immediately; after release, 0110 alone produces no match.
